mem_in_reader: RTL and testbench

- Sequential read engine placed directly downstream of the mem_in SRAM (32768 x 8, active-low CEN/WEN, 1-cycle read latency).
- On a start command it reads a contiguous block of bytes, compensates for the SRAM read latency, and presents them as a valid/ready byte stream to the systolic-array input feeder.
- A small credit-controlled FIFO absorbs backpressure, so no SRAM read is ever lost.

---
 rtl/mem_in_reader.sv | 181 ++++++++++++++++++
 tb/tb_mem_in_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_in_reader.sv
// mem_in_reader: block read engine for the mem_in SRAM (1-cycle read latency).
// Streams bytes through a small FIFO; reads are only issued when the FIFO has room for them.
module mem_in_reader #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              CEN,
   output logic              WEN,
   output logic [ADDR_W-1:0] A,
   input  logic [DATA_W-1:0] Q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t state, state_nx;

   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  iss_cnt;
   logic [LEN_W-1:0]  pop_cnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] a_hold;
   logic              q_pend;
   logic              zdone;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fcnt;

   logic accept;
   logic issue;
   logic last_iss;
   logic last_pop;
   logic credit;
   logic push;
   logic pop;

   // A byte returns from the SRAM one cycle after its read was issued.
   assign push      = q_pend;
   assign out_valid = (fcnt != '0);
   assign pop       = out_valid & out_ready;
   assign out_data  = fifo_mem[rd_ptr];

   // Room check counts stored bytes plus the one in flight; a same-cycle pop is not credited.
   assign credit = ({1'b0, fcnt} + {{CW{1'b0}}, q_pend}) < DEPTH_C;

   assign WEN  = 1'b1;
   assign CEN  = ~issue;
   assign A    = issue ? rd_addr : a_hold;
   assign busy = (state != IDLE);
   assign done = zdone | last_pop;

   // Next-state and read-issue decode.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      issue    = 1'b0;
      last_iss = 1'b0;
      last_pop = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && (len != '0)) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            issue    = (iss_cnt < len_r) && credit;
            last_iss = issue && (iss_cnt == len_r - 1'b1);
            if (last_iss) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            last_pop = pop && (pop_cnt == len_r - 1'b1);
            if (last_pop) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Transfer bookkeeping: length, address, issue and pop counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r   <= '0;
         iss_cnt <= '0;
         pop_cnt <= '0;
         rd_addr <= '0;
         a_hold  <= '0;
         q_pend  <= 1'b0;
         zdone   <= 1'b0;
      end else begin
         zdone  <= (state == IDLE) && start && (len == '0);
         q_pend <= issue;
         if (accept) begin
            len_r   <= len;
            rd_addr <= base_addr;
            iss_cnt <= '0;
            pop_cnt <= '0;
         end else begin
            if (issue) begin
               rd_addr <= rd_addr + 1'b1;
               a_hold  <= rd_addr;
               iss_cnt <= iss_cnt + 1'b1;
            end
            if (pop) begin
               pop_cnt <= pop_cnt + 1'b1;
            end
         end
      end
   end

   // Output FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= Q;
            wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            fcnt <= fcnt + 1'b1;
         end else if (pop && !push) begin
            fcnt <= fcnt - 1'b1;
         end
      end
   end

   // A push into a full FIFO would drop a byte; the credit check keeps this unreachable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && (fcnt == FULL_C)))
         else $error("mem_in_reader: FIFO overflow");
      end
   end

endmodule

// File: tb/tb_mem_in_reader.sv
// tb_mem_in_reader: directed and random transfers against an SRAM model.
// Expected bytes and addresses come from the memory image and base/len arithmetic.
module tb_mem_in_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [14:0] base_addr = '0;
   logic [15:0] len = '0;
   logic        busy;
   logic        done;
   logic        CEN;
   logic        WEN;
   logic [14:0] A;
   logic [7:0]  Q = '0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;

   logic [7:0]  mem [0:32767];

   int ncheck = 0;
   int npass  = 0;
   int nfail  = 0;

   // Monitor state (written only by the monitor processes).
   int          cyc = 0;
   logic [7:0]  got [$];
   logic [14:0] addrs [$];
   int hs_total = 0, cen_total = 0, lost = 0;
   int done_total = 0, done_hs = 0, done_cyc = 0;
   int busy_total = 0, v_rise = 0, cen_fall = 0, hs_last = 0;
   int stall_bad = 0, credit_bad = 0, wen_bad = 0;
   logic       pv = 1'b0, pr = 1'b0, pc = 1'b1;
   logic [7:0] pd = '0;

   // Per-transfer snapshots (written only by the stimulus process).
   int s_got, s_addr, s_hs, s_cen, s_done, s_busy, s_cyc;

   always #5 clk = ~clk;

   mem_in_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .CEN       (CEN),
      .WEN       (WEN),
      .A         (A),
      .Q         (Q),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always @(posedge clk) begin
      if (CEN === 1'b0) Q <= mem[A];
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (WEN !== 1'b1) wen_bad++;
      if (rst) begin
         lost = cen_total - hs_total;
         pv = 1'b0;
         pr = 1'b0;
         pc = 1'b1;
      end else begin
         if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) stall_bad++;
         if (CEN === 1'b0) begin
            if (cen_total - hs_total - lost >= 4) credit_bad++;
            if (pc) cen_fall = cyc;
            addrs.push_back(A);
            cen_total++;
         end
         if (out_valid === 1'b1 && !pv) v_rise = cyc;
         if (busy === 1'b1) busy_total++;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got.push_back(out_data);
            hs_total++;
            hs_last = cyc;
         end
         if (done === 1'b1) begin
            done_total++;
            done_hs  = hs_total;
            done_cyc = cyc;
         end
         pv = out_valid;
         pr = out_ready;
         pd = out_data;
         pc = CEN;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      ncheck++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int mode, input int k);
      if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
      if (mode == 2) return 1'($urandom_range(0, 1));
      return 1'b1;
   endfunction

   task automatic snap();
      s_got  = got.size();
      s_addr = addrs.size();
      s_hs   = hs_total;
      s_cen  = cen_total;
      s_done = done_total;
      s_busy = busy_total;
      s_cyc  = cyc;
   endtask

   task automatic xfer(input string t, input int b, input int n,
                       input int mode);
      int k;
      snap();
      base_addr = 15'(b);
      len = 16'(n);
      start = 1'b1;
      out_ready = rdy(mode, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 1;
      while (done_total == s_done && k < 4 * n + 40) begin
         out_ready = rdy(mode, k);
         @(posedge clk);
         #1;
         k++;
      end
      out_ready = 1'b1;
      chk({t, "_done_seen"}, 64'(done_total != s_done), 1);
      chk({t, "_busy_after"}, busy, 0);
      @(posedge clk);
      #1;
      chk({t, "_done_once"}, done_total - s_done, 1);
   endtask

   task automatic verify(input string t, input int b, input int n);
      int de = 0;
      int ae = 0;
      for (int i = 0; i < n; i++) begin
         if (s_got + i >= got.size()) de++;
         else if (got[s_got + i] !== mem[(b + i) % 32768]) de++;
         if (s_addr + i >= addrs.size()) ae++;
         else if (addrs[s_addr + i] !== 15'((b + i) % 32768)) ae++;
      end
      chk({t, "_count"}, got.size() - s_got, n);
      chk({t, "_data"}, de, 0);
      chk({t, "_reads"}, cen_total - s_cen, n);
      chk({t, "_addr"}, ae, 0);
      chk({t, "_done_at_last_hs"}, done_hs - s_hs, n);
   endtask

   initial begin
      int b;
      int n;
      int k;
      for (int i = 0; i < 32768; i++) mem[i] = 8'(i);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cen", CEN, 1);
      chk("rst_wen", WEN, 1);
      chk("rst_a", A, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      xfer("t8", 0, 8, 0);
      verify("t8", 0, 8);
      chk("t8_cen_lat", cen_fall - s_cyc, 1);
      chk("t8_valid_lat", v_rise - s_cyc, 3);
      chk("t8_tput", hs_last - v_rise, 7);

      xfer("wrap", 32766, 4, 0);
      verify("wrap", 32766, 4);

      xfer("zero", 0, 0, 0);
      chk("zero_done_lat", done_cyc - s_cyc, 1);
      chk("zero_busy", busy_total - s_busy, 0);
      chk("zero_reads", cen_total - s_cen, 0);

      xfer("stall", 100, 16, 1);
      verify("stall", 100, 16);
      chk("stall_stable", stall_bad, 0);
      chk("stall_credit", credit_bad, 0);

      xfer("full", 0, 32768, 0);
      verify("full", 0, 32768);

      snap();
      base_addr = 15'd300;
      len = 16'd20;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      while (hs_total - s_hs < 5 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("abort_hs5", hs_total - s_hs, 5);
      rst = 1'b1;
      #1;
      chk("abort_cen", CEN, 1);
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_total - s_done, 0);
      chk("abort_idle", busy, 0);

      xfer("after", 0, 2, 0);
      verify("after", 0, 2);

      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      for (int r = 0; r < 4; r++) begin
         b = int'($urandom_range(0, 32767));
         n = int'($urandom_range(1, 40));
         xfer("rnd", b, n, 2);
         verify("rnd", b, n);
      end

      chk("stable_all", stall_bad, 0);
      chk("credit_all", credit_bad, 0);
      chk("wen_all", wen_bad, 0);

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule
